imem_sync: RTL
==============

# imem_sync

Synchronous, parametrised instruction memory for the MIPS core: a word-addressed RAM with a one-cycle registered read, a valid/ready fetch handshake with response back-pressure, and a program-loader write port. It replaces the combinational 32-word instruction ROM in the fetch stage. It reports misaligned and out-of-range fetches so CP0 can raise an instruction-fetch exception.

## Interface
- `DEPTH_LOG2`, default 5: log2 of the number of words (32 words by default).
- `WORD_W`, default 32: instruction width in bits.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Clrn`  in  1  reset. Asynchronous, active-low.
- `ReqValid`  in  1  fetch request present.
- `ReqReady`  out  1  request accepted this cycle.
- `Addr`  in  32  fetch byte address.
- `RspValid`  out  1  response register holds data.
- `RspReady`  in  1  consumer takes the response.
- `Inst`  out  WORD_W  fetched instruction.
- `Fault`  out  2  bit0 = misaligned; bit1 = out of range.
- `ParErr`  out  1  parity mismatch on the read word. Present only with `IMEM_PARITY_EN`.
- `LdEn`  in  1  loader write strobe.
- `LdAddr`  in  DEPTH_LOG2  loader word index.
- `LdData`  in  WORD_W  loader write data.

## Operation
- Word index: `idx = (Addr - BASE_ADDR) >> 2`.
- Misaligned: `Addr[1:0] != 0`.
- Out of range: `Addr < BASE_ADDR`, or `idx >= 2**DEPTH_LOG2`.
- `ReqReady = !LdEn && (!RspValid || RspReady)`.
- Accept occurs when `ReqValid && ReqReady`. On accept, next cycle: `RspValid = 1`, and `Fault` takes the flags computed for that request.
  - No fault: `Inst = mem[idx]`.
  - Any fault: `Inst = 0` (NOP) and the RAM is not read.
- No accept and `RspReady = 1`: `RspValid` clears. `Inst` and `Fault` keep their old values.
- No accept and `RspReady = 0`: outputs are held unchanged.
- Loader:
  - With `LdEn = 1`, `mem[LdAddr] <= LdData` at the clock edge.
  - The loader has priority: no request is accepted in that cycle.
  - `LdAddr` always indexes a valid word, so there is no loader range check.
- Reset (`Clrn = 0`, at any time): `RspValid = 0`, `Inst = 0`, `Fault = 0`, `ParErr = 0`.
  - An in-flight response is discarded.
  - Memory contents are not cleared.
- Response state machine:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept together with `RspReady` (back-to-back).
  - FULL → EMPTY on `RspReady` with no accept.
  - FULL holds while `RspReady = 0`.

## Timing
- Read latency is 1 cycle from accept to `RspValid`.
- Throughput is 1 fetch per cycle while `RspReady = 1` and `LdEn = 0`.
- `ReqReady` depends combinationally on `LdEn`, `RspValid` and `RspReady`. It never depends on `ReqValid`.
- A write and a read to the same word cannot occur in the same cycle, because the loader blocks accepts.
- A fetch accepted in the cycle after a write returns the newly written data.
- `Inst`, `Fault` and `ParErr` all come from flops. There is no combinational path from `Addr` to the outputs.

## Configuration
- `IMEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed from `LdData` on write.
  - A read recomputes parity. `ParErr = 1` in the response cycle on mismatch.
  - Any fault forces `ParErr = 0`.
- `IMEM_PARITY_EN` undefined: no parity storage, and the `ParErr` port is absent.

## Structure
- The shared package `imem_pkg` holds:
  - fault bit positions `FAULT_MISALIGN = 0` and `FAULT_RANGE = 1`;
  - the NOP encoding `32'h0000_0000`;
  - the parity function.
- One sub-module, `imem_ram`: a single write port and a registered single read port, with parity storage under the macro.
- Handshake and fault logic live in the top module.

## Test plan
- **Load and fetch:**
  - Stimulus: load word 0 = `32'h23DE000F` and word 4 = `32'h00411820`; fetch `Addr` 0x00, then 0x10, with `RspReady = 1`.
  - Response: `Inst` = `32'h23DE000F`, then `32'h00411820`, one cycle after each accept; `Fault = 0`.
- **Misaligned and out of range** (`DEPTH_LOG2 = 5`):
  - Fetch `Addr` 0x06 → `Fault = 2'b01`, `Inst = 0`.
  - Fetch `Addr` 0x80 → `Fault = 2'b10`, `Inst = 0`.
  - Fetch `Addr` 0x7C → `Fault = 0`, last word returned.
- **Back-pressure:**
  - Stimulus: accept a fetch of 0x08; hold `RspReady = 0` for 3 cycles.
  - Response: `ReqReady = 0`, and `RspValid`/`Inst` stable throughout.
  - After `RspReady = 1`, the next request is accepted in the same cycle.
- **Loader priority:**
  - Stimulus: `LdEn = 1` (LdAddr 2, LdData `32'hDEADBEEF`) while `ReqValid` targets 0x08.
  - Response: no accept that cycle; the next-cycle fetch returns `32'hDEADBEEF`.
- **Reset mid-operation:**
  - Stimulus: assert `Clrn = 0` asynchronously while `RspValid = 1`.
  - Response: `RspValid`, `Inst` and `Fault` go to 0 immediately; after release, memory still returns the loaded values.
- **Parity** (`IMEM_PARITY_EN`):
  - Stimulus: load word 1, then force a bit flip in `imem_ram`; fetch 0x04.
  - Response: `ParErr = 1`, `Fault = 0`.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction memory: fault bit
// positions, the NOP encoding and the even-parity helper.
package imem_pkg;

  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_RANGE    = 1;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam int unsigned PAR_MAX_W = 64;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Even-parity bit over a zero-extended word (zero padding does not change it).
  function automatic logic parity_even(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single write port / registered single read port word RAM for imem_sync.
// With IMEM_PARITY_EN defined, each word carries an even-parity bit checked on read.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  input  logic                  clr_i,
`ifdef IMEM_PARITY_EN
  output logic                  par_err_o,
`endif
  output logic [WORD_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

`ifdef IMEM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic par_err_q;

  // Loader write of data plus its parity bit; storage is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i]     <= wdata_i;
      par_mem_q[waddr_i] <= parity_even({{(PAR_MAX_W-WORD_W){1'b0}}, wdata_i});
    end
  end

  // Parity check is captured together with the read word; a faulted fetch clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_err_q <= 1'b0;
    end else if (re_i) begin
      par_err_q <= parity_even({{(PAR_MAX_W-WORD_W){1'b0}}, mem_q[raddr_i]}) ^ par_mem_q[raddr_i];
    end else if (clr_i) begin
      par_err_q <= 1'b0;
    end
  end

  assign par_err_o = par_err_q;
`else
  // Loader write; storage is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`endif

  // Read register holds between reads; clr loads the NOP without touching the array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= WORD_W'(NOP_INST);
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else if (clr_i) begin
      rdata_q <= WORD_W'(NOP_INST);
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// Instruction memory with valid/ready fetch handshake, fault reporting and loader port.
// Optional macro IMEM_PARITY_EN adds per-word parity and the ParErr output.
module imem_sync
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WORD_W     = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [31:0]           Addr,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [WORD_W-1:0]     Inst,
  output logic [1:0]            Fault,
`ifdef IMEM_PARITY_EN
  output logic                  ParErr,
`endif
  input  logic                  LdEn,
  input  logic [DEPTH_LOG2-1:0] LdAddr,
  input  logic [WORD_W-1:0]     LdData
);

  rsp_state_e            state_q, state_d;
  logic [1:0]            fault_q, fault_d;
  logic [31:0]           offset_s;
  logic [1:0]            fault_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  accept_s;
  logic                  rd_en_s;
  logic                  clr_s;

  assign ReqReady = !LdEn && ((state_q == RSP_EMPTY) || RspReady);
  assign accept_s = ReqValid && ReqReady;

  // Address decode: word index and the two fault flags for the current request.
  always_comb begin
    offset_s                = Addr - BASE_ADDR;
    fault_s                 = 2'b00;
    fault_s[FAULT_MISALIGN] = (Addr[1:0] != 2'b00);
    fault_s[FAULT_RANGE]    = (Addr < BASE_ADDR) || ((offset_s >> (DEPTH_LOG2 + 2)) != 32'd0);
    idx_s                   = offset_s[DEPTH_LOG2+1:2];
  end

  assign rd_en_s = accept_s && (fault_s == 2'b00);
  assign clr_s   = accept_s && (fault_s != 2'b00);

  // Response slot next state and fault capture.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (accept_s) begin
      fault_d = fault_s;
    end else begin
      fault_d = fault_q;
    end
    case (state_q)
      RSP_EMPTY: begin
        if (accept_s) begin
          state_d = RSP_FULL;
        end else begin
          state_d = RSP_EMPTY;
        end
      end
      RSP_FULL: begin
        if (accept_s) begin
          state_d = RSP_FULL;
        end else if (RspReady) begin
          state_d = RSP_EMPTY;
        end else begin
          state_d = RSP_FULL;
        end
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  // Response state and fault flags; reset discards any in-flight response.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= RSP_EMPTY;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign RspValid = (state_q == RSP_FULL);
  assign Fault    = fault_q;

  imem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WORD_W    (WORD_W)
  ) u_ram (
    .clk_i    (Clk),
    .rst_ni   (Clrn),
    .we_i     (LdEn),
    .waddr_i  (LdAddr),
    .wdata_i  (LdData),
    .re_i     (rd_en_s),
    .raddr_i  (idx_s),
    .clr_i    (clr_s),
`ifdef IMEM_PARITY_EN
    .par_err_o(ParErr),
`endif
    .rdata_o  (Inst)
  );

endmodule
